// File: rtl/me_result_collector.sv
// me_result_collector: captures motion-estimator results {motionX, motionY, bestDistance} into a FIFO.
// Define ME_RESULT_STATS_EN to add sad_sum/sad_max statistics outputs.
module me_result_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     completed,
  input  logic [7:0]               bestDistance,
  input  logic [3:0]               motionX,
  input  logic [3:0]               motionY,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [CNT_W-1:0]         block_count,
`ifdef ME_RESULT_STATS_EN
  output logic [23:0]              sad_sum,
  output logic [7:0]               sad_max,
`endif
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state;
  logic completed_q;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic capture, pop, full, accept, drop;
  assign capture   = start && state == WAIT && completed && !completed_q;
  assign out_valid = level != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;
  assign full      = level == (AW+1)'(DEPTH);
  // a full FIFO still takes the word when the head leaves on the same edge
  assign accept    = capture && (!full || pop);
  assign drop      = capture && full && !pop;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state       <= IDLE;
      completed_q <= 1'b0;
    end else begin
      completed_q <= completed;
      state       <= !start ? IDLE :
                     state == IDLE ? WAIT :
                     capture ? HOLD :
                     (state == HOLD && !completed) ? WAIT : state;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      block_count <= '0;
    end else begin
      wr_ptr      <= accept ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
      level       <= level + (AW+1)'(accept) - (AW+1)'(pop);
      overflow    <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
      block_count <= accept ? block_count + CNT_W'(1) : block_count;
    end
  always_ff @(posedge clock)
    if (accept) mem[wr_ptr] <= {motionX, motionY, bestDistance};
`ifdef ME_RESULT_STATS_EN
  logic [24:0] sum_ext;
  assign sum_ext = {1'b0, sad_sum} + 25'(bestDistance);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sad_sum <= '0;
      sad_max <= '0;
    end else if (accept) begin
      sad_sum <= sum_ext[24] ? '1 : sum_ext[23:0];
      sad_max <= bestDistance > sad_max ? bestDistance : sad_max;
    end
`endif
endmodule

// File: tb/tb_me_result_collector.sv
// tb_me_result_collector: scoreboard bench for me_result_collector (DEPTH=8, CNT_W=16).
module tb_me_result_collector;
  logic clock = 0, reset = 1, start = 0, completed = 0, out_ready = 0, clr_overflow = 0;
  logic [7:0] bestDistance = 0;
  logic [3:0] motionX = 0, motionY = 0;
  logic [15:0] out_data;
  logic out_valid, overflow;
  logic [15:0] block_count;
  logic [3:0] level;
`ifdef ME_RESULT_STATS_EN
  logic [23:0] sad_sum;
  logic [7:0] sad_max;
`endif
  me_result_collector #(.DEPTH(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .completed(completed),
    .bestDistance(bestDistance), .motionX(motionX), .motionY(motionY),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clr_overflow(clr_overflow), .block_count(block_count),
`ifdef ME_RESULT_STATS_EN
    .sad_sum(sad_sum), .sad_max(sad_max),
`endif
    .level(level));
  always #5 clock = ~clock;
  int n_vec = 0, n_err = 0;
  int exp_count = 0, exp_sum = 0, exp_max = 0;
  bit exp_ovf = 0;
  logic [15:0] sb [$];
  task automatic tick();
    @(posedge clock); #1;
  endtask
  task automatic reset_dut();
    tick();
    reset = 1; start = 0; completed = 0; out_ready = 0; clr_overflow = 0;
    tick(); tick();
    reset = 0;
    sb.delete(); exp_count = 0; exp_ovf = 0; exp_sum = 0; exp_max = 0;
  endtask
  // one completion pulse: capture edge, then completed low to return to WAIT
  task automatic do_block(input logic [3:0] x, input logic [3:0] y, input logic [7:0] d, input bit rdy);
    bit pop, full;
    motionX = x; motionY = y; bestDistance = d; completed = 1; out_ready = rdy;
    pop = rdy && sb.size() > 0;
    full = sb.size() == 8;
    if (pop) begin
      n_vec++;
      if (out_data !== sb[0]) begin n_err++; $display("FAIL pop_data got=%h want=%h", out_data, sb[0]); end
      void'(sb.pop_front());
    end
    if (!full || pop) begin
      sb.push_back({x, y, d});
      exp_count++;
      exp_sum = (exp_sum + d > 24'hFFFFFF) ? 24'hFFFFFF : exp_sum + d;
      exp_max = d > exp_max ? d : exp_max;
    end else exp_ovf = 1;
    if (!(full && !pop) && clr_overflow) exp_ovf = 0;
    tick();
    completed = 0; out_ready = 0; clr_overflow = 0;
    tick();
  endtask
  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== sb[0]) begin
        n_err++; $display("FAIL drain_head valid=%b got=%h want=%h", out_valid, out_data, sb[0]);
      end
      void'(sb.pop_front());
      tick();
    end
    out_ready = 0;
    n_vec++;
    if (out_valid !== 1'b0 || level !== 4'd0 || out_data !== 16'h0) begin
      n_err++; $display("FAIL drain_empty valid=%b level=%0d data=%h want 0/0/0", out_valid, level, out_data);
    end
  endtask
  task automatic test_reset();
    reset = 1; tick(); tick();
    n_vec++;
    if ({out_valid, overflow, level, block_count, out_data} !== '0) begin
      n_err++; $display("FAIL reset_state valid=%b ovf=%b level=%0d count=%0d data=%h want all 0",
                        out_valid, overflow, level, block_count, out_data);
    end
    reset = 0;
  endtask
  task automatic test_basic();
    reset_dut();
    start = 1; tick();
    motionX = 4'hD; motionY = 4'h5; bestDistance = 8'h2A; completed = 1;
    tick();
    sb.push_back(16'hD52A); exp_count = 1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 16'hD52A) begin
      n_err++; $display("FAIL basic_out valid=%b data=%h want 1/d52a", out_valid, out_data);
    end
    n_vec++;
    if (block_count !== 16'd1 || level !== 4'd1) begin
      n_err++; $display("FAIL basic_cnt count=%0d level=%0d want 1/1", block_count, level);
    end
    completed = 0; tick();
    drain();
  endtask
  task automatic test_hold();
    reset_dut();
    start = 1; tick();
    motionX = 4'h1; motionY = 4'hF; bestDistance = 8'h33; completed = 1;
    sb.push_back(16'h1F33); exp_count = 1;
    repeat (10) tick();
    n_vec++;
    if (level !== 4'd1 || block_count !== 16'd1) begin
      n_err++; $display("FAIL hold_single level=%0d count=%0d want 1/1", level, block_count);
    end
    completed = 0; tick();
    do_block(4'h7, 4'h8, 8'h44, 0);
    n_vec++;
    if (level !== 4'd2 || block_count !== 16'd2) begin
      n_err++; $display("FAIL hold_second level=%0d count=%0d want 2/2", level, block_count);
    end
    drain();
  endtask
  task automatic test_overflow();
    reset_dut();
    start = 1; tick();
    for (int i = 0; i < 9; i++) do_block(4'(i), 4'(~i), 8'(8'h10 + i), 0);
    n_vec++;
    if (level !== 4'd8 || overflow !== 1'b1 || block_count !== 16'(exp_count) || exp_count != 8) begin
      n_err++; $display("FAIL ovf_full level=%0d ovf=%b count=%0d want 8/1/8", level, overflow, block_count);
    end
    clr_overflow = 1; tick(); clr_overflow = 0; exp_ovf = 0;
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    clr_overflow = 1;
    do_block(4'h3, 4'h3, 8'h99, 0);
    n_vec++;
    if (overflow !== exp_ovf || block_count !== 16'(exp_count)) begin
      n_err++; $display("FAIL ovf_set_wins ovf=%b count=%0d want %b/%0d", overflow, block_count, exp_ovf, exp_count);
    end
    clr_overflow = 1; tick(); clr_overflow = 0; exp_ovf = 0;
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear2 got=%b want=0", overflow); end
  endtask
  task automatic test_full_pop();
    do_block(4'hA, 4'hB, 8'hCD, 1);
    n_vec++;
    if (level !== 4'd8 || overflow !== 1'b0 || block_count !== 16'd9) begin
      n_err++; $display("FAIL fullpop level=%0d ovf=%b count=%0d want 8/0/9", level, overflow, block_count);
    end
    drain();
  endtask
  task automatic test_start_fall();
    reset_dut();
    start = 1; tick();
    motionX = 4'h2; motionY = 4'h6; bestDistance = 8'h5A; completed = 1;
    tick();
    sb.push_back(16'h265A); exp_count = 1;
    start = 0; tick();
    start = 1; tick(); tick();
    n_vec++;
    if (level !== 4'd1 || block_count !== 16'd1) begin
      n_err++; $display("FAIL start_hold level=%0d count=%0d want 1/1", level, block_count);
    end
    completed = 0; tick();
    start = 0; tick();
    completed = 1; tick(); tick();
    n_vec++;
    if (level !== 4'd1 || block_count !== 16'd1) begin
      n_err++; $display("FAIL start_idle level=%0d count=%0d want 1/1", level, block_count);
    end
    completed = 0; start = 1; tick();
    do_block(4'h9, 4'h0, 8'h01, 0);
    n_vec++;
    if (level !== 4'd2 || block_count !== 16'd2) begin
      n_err++; $display("FAIL start_resume level=%0d count=%0d want 2/2", level, block_count);
    end
    drain();
  endtask
  task automatic test_async_reset();
    reset_dut();
    start = 1; tick();
    do_block(4'h1, 4'h1, 8'h11, 0);
    do_block(4'h2, 4'h2, 8'h22, 0);
    motionX = 4'h3; motionY = 4'h3; bestDistance = 8'h33; completed = 1;
    tick();
    n_vec++;
    if (level !== 4'd3) begin n_err++; $display("FAIL arst_pre level=%0d want 3", level); end
    #2 reset = 1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || level !== 4'd0 || block_count !== 16'd0) begin
      n_err++; $display("FAIL arst_now valid=%b level=%0d count=%0d want 0/0/0", out_valid, level, block_count);
    end
    completed = 0;
    reset_dut();
  endtask
`ifdef ME_RESULT_STATS_EN
  task automatic test_stats();
    reset_dut();
    start = 1; tick();
    do_block(4'h0, 4'h0, 8'hFF, 0);
    do_block(4'h0, 4'h0, 8'h10, 0);
    do_block(4'h0, 4'h0, 8'h80, 0);
    n_vec++;
    if (sad_sum !== 24'h18F || sad_max !== 8'hFF || sad_sum !== 24'(exp_sum) || sad_max !== 8'(exp_max)) begin
      n_err++; $display("FAIL stats sum=%h max=%h want 18f/ff", sad_sum, sad_max);
    end
    drain();
  endtask
`endif
  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_full_pop();
    test_start_fall();
    test_async_reset();
`ifdef ME_RESULT_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
